mod_codec_config_seq: RTL
=========================

Name: mod_codec_config_seq

Overview:
Sequencer that drives the one-shot I2C write master through a fixed 11-entry audio-codec init table (7-bit register, 9-bit data per entry). The master runs one transaction each time its reset is released. This block holds the master in reset, presents the operands, releases it, and judges the result from the master's done and fault-code outputs. It also handles retries, timeouts, and overall done/error status for the top level.

Parameters:
I2C_ADDR, 7'h1A, codec 7-bit slave address driven on o_m_addr.
MAX_RETRIES, 3, extra attempts per entry after the first failure (retry feature only).
TIMEOUT_CYCLES, 128, RUN cycles allowed before declaring timeout; must be >= 64.
GAP_CYCLES, 4, idle cycles between transactions, with the master held in reset.

Ports:
i_i2c_clk  in  1  clock, shared with the I2C master.
i_nrst  in  1  reset, asynchronous, active-low.
i_start  in  1  one-cycle pulse; starts the sequence from entry 0.
o_busy  out  1  high from accepted start until DONE or FAIL.
o_done  out  1  high in DONE; all entries written successfully.
o_error  out  1  high in FAIL.
o_error_code  out  4  failing fault code (1-5 from master, 4'hE timeout).
o_error_index  out  4  table index that failed.
o_m_nrst  out  1  master reset, active-low.
o_m_addr  out  7  to master i_i2c_addr; equals I2C_ADDR.
o_m_register  out  7  to master i_i2c_register.
o_m_data  out  9  to master i_i2c_data.
o_m_read_not_write  out  1  constant 0.
i_m_done  in  1  master o_done.
i_m_fault_code  in  4  master o_fault_code.

Behaviour:
- Reset (async): state IDLE. o_m_nrst=0, o_busy=0, o_done=0, o_error=0, o_error_code=0, o_error_index=0, index=0, retry count=0, timer=0.
- Init table (index: reg, data):
  - 0: 0x0F, 0x000
  - 1: 0x06, 0x000
  - 2: 0x00, 0x017
  - 3: 0x01, 0x017
  - 4: 0x02, 0x079
  - 5: 0x03, 0x079
  - 6: 0x04, 0x012
  - 7: 0x05, 0x000
  - 8: 0x07, 0x002
  - 9: 0x08, 0x000
  - 10: 0x09, 0x001
- o_m_register and o_m_data are registered from index and stay stable in every state other than IDLE.
- IDLE: o_m_nrst=0. i_start -> LOAD with index=0 and retry count=0; o_busy=1 from the next cycle.
- LOAD: exactly 2 cycles, o_m_nrst=0, operands stable -> RUN.
- RUN: o_m_nrst=1; timer counts from 0.
  - Cycles 0-1 are blanking: the fault code is ignored, because the master's fault register holds a stale value until its first post-reset clock.
  - After blanking, success: i_m_done=1 and i_m_fault_code=4'hF.
  - After blanking, fault: i_m_fault_code is neither 0 nor 4'hF.
  - Timeout: timer reaches TIMEOUT_CYCLES-1 with neither condition -> fault, code 4'hE.
  - Success and fault never coincide; success has priority.
- Success:
  - index=10 -> DONE.
  - Otherwise index++, retry count=0 -> GAP.
- Fault: see Optional Feature for whether to retry (GAP, same index) or go to FAIL.
- GAP: o_m_nrst=0 for GAP_CYCLES cycles -> LOAD.
- DONE: o_done=1, o_busy=0, o_m_nrst=0. i_start -> clears o_done, restarts at index 0.
- FAIL: o_error=1, o_busy=0, o_m_nrst=0; o_error_code and o_error_index are latched on entry. i_start -> clears error outputs, restarts at index 0.
- i_start in LOAD, RUN or GAP is ignored.
- Reset mid-RUN: o_m_nrst drops in the same instant (async), which aborts the master and releases SDAT.
- Each transaction occupies LOAD(2) + RUN(~62) cycles; transaction pitch ~ 2 + 62 + GAP_CYCLES.

Optional Feature:
Macro CODEC_CFG_RETRY_EN.
- Defined: on a fault, if retry count < MAX_RETRIES, retry count++ and go to GAP, then repeat the same index. If retry count = MAX_RETRIES, go to FAIL.
- Undefined: the first fault goes directly to FAIL; the retry counter logic and the MAX_RETRIES parameter are unused.

Test Plan:
- ACKing slave model plus real master; pulse i_start -> exactly 11 transactions in table order (e.g. entry 4 shows reg 0x02, data 0x079). o_m_nrst low 2 cycles before each transaction and GAP_CYCLES between them. o_done=1 and o_busy=0 after the last one. o_error stays 0.
- With retry enabled, slave NACKs the address once at index 3 -> master fault 2 seen, index 3 re-sent, 12 transactions total, o_done=1.
- Slave NACKs data at index 5 permanently:
  - Retry enabled -> 4 attempts, then o_error=1, o_error_code=4, o_error_index=5.
  - Macro undefined -> 1 attempt, same code and index.
- Master stub with i_m_done stuck 0 and fault 0 -> FAIL after TIMEOUT_CYCLES in RUN, o_error_code=4'hE, o_error_index=0.
- Stub holds stale fault 2 during blanking, then reports success -> no fault taken, sequence advances.
- i_nrst pulsed low mid-RUN at index 6 -> o_m_nrst=0 immediately, all outputs at reset values. Next i_start restarts at index 0.
- i_start during RUN is ignored (index unchanged). i_start in DONE restarts with o_done cleared on the next cycle.

Source files
------------

// File: rtl/mod_codec_config_seq.sv
// Walks the one-shot I2C write master through the 11-entry codec init table, judging each pass from done/fault.
// Optional macro CODEC_CFG_RETRY_EN enables bounded per-entry retries; otherwise the first fault ends the sequence.
module mod_codec_config_seq #(
    parameter logic [6:0] I2C_ADDR       = 7'h1A,
    parameter int         MAX_RETRIES    = 3,
    parameter int         TIMEOUT_CYCLES = 128,
    parameter int         GAP_CYCLES     = 4
) (
    input  logic       i_i2c_clk,
    input  logic       i_nrst,
    input  logic       i_start,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_error,
    output logic [3:0] o_error_code,
    output logic [3:0] o_error_index,
    output logic       o_m_nrst,
    output logic [6:0] o_m_addr,
    output logic [6:0] o_m_register,
    output logic [8:0] o_m_data,
    output logic       o_m_read_not_write,
    input  logic       i_m_done,
    input  logic [3:0] i_m_fault_code
);

    // One width serves the LOAD/RUN/GAP timer and the retry counter.
    localparam int CNT_A   = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int CNT_TOP = (CNT_A > MAX_RETRIES) ? CNT_A : MAX_RETRIES;
    localparam int TW      = $clog2(CNT_TOP + 1);
    localparam logic [3:0] LAST_IDX = 4'd10;
    localparam logic [3:0] CODE_OK  = 4'hF;
    localparam logic [3:0] CODE_TMO = 4'hE;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RUN, S_GAP, S_DONE, S_FAIL
    } state_t;

    function automatic logic [15:0] init_entry(input logic [3:0] idx);
        case (idx)
            4'd0:    init_entry = {7'h0F, 9'h000};
            4'd1:    init_entry = {7'h06, 9'h000};
            4'd2:    init_entry = {7'h00, 9'h017};
            4'd3:    init_entry = {7'h01, 9'h017};
            4'd4:    init_entry = {7'h02, 9'h079};
            4'd5:    init_entry = {7'h03, 9'h079};
            4'd6:    init_entry = {7'h04, 9'h012};
            4'd7:    init_entry = {7'h05, 9'h000};
            4'd8:    init_entry = {7'h07, 9'h002};
            4'd9:    init_entry = {7'h08, 9'h000};
            4'd10:   init_entry = {7'h09, 9'h001};
            default: init_entry = {7'h0F, 9'h000};
        endcase
    endfunction

    state_t        state_q, state_d;
    logic [3:0]    index_q, index_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    err_code_q, err_code_d;
    logic [3:0]    err_idx_q, err_idx_d;
    logic [6:0]    reg_q, reg_d;
    logic [8:0]    data_q, data_d;
`ifdef CODEC_CFG_RETRY_EN
    logic [TW-1:0] retry_q, retry_d;
`endif

    logic       blanking;
    logic       run_ok;
    logic       run_bad;
    logic       run_tmo;
    logic [3:0] fault_code;
    logic [15:0] entry;

    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        timer_d    = timer_q;
        err_code_d = err_code_q;
        err_idx_d  = err_idx_q;
`ifdef CODEC_CFG_RETRY_EN
        retry_d    = retry_q;
`endif
        // The master's fault register is stale for its first post-reset clocks.
        blanking   = (timer_q < TW'(2));
        run_ok     = !blanking && i_m_done && (i_m_fault_code == CODE_OK);
        run_bad    = !blanking && (i_m_fault_code != 4'h0) && (i_m_fault_code != CODE_OK);
        run_tmo    = (timer_q == TW'(TIMEOUT_CYCLES - 1));
        fault_code = run_bad ? i_m_fault_code : CODE_TMO;

        case (state_q)
            S_IDLE, S_DONE, S_FAIL: begin
                if (i_start) begin
                    state_d    = S_LOAD;
                    index_d    = 4'd0;
                    timer_d    = '0;
                    err_code_d = 4'h0;
                    err_idx_d  = 4'h0;
`ifdef CODEC_CFG_RETRY_EN
                    retry_d    = '0;
`endif
                end
            end
            S_LOAD: begin
                timer_d = timer_q + TW'(1);
                if (timer_q == TW'(1)) begin
                    state_d = S_RUN;
                    timer_d = '0;
                end
            end
            S_RUN: begin
                timer_d = timer_q + TW'(1);
                if (run_ok) begin
                    timer_d = '0;
                    if (index_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_GAP;
                        index_d = index_q + 4'd1;
`ifdef CODEC_CFG_RETRY_EN
                        retry_d = '0;
`endif
                    end
                end else if (run_bad || run_tmo) begin
                    timer_d = '0;
`ifdef CODEC_CFG_RETRY_EN
                    if (retry_q < TW'(MAX_RETRIES)) begin
                        state_d = S_GAP;
                        retry_d = retry_q + TW'(1);
                    end else begin
                        state_d    = S_FAIL;
                        err_code_d = fault_code;
                        err_idx_d  = index_q;
                    end
`else
                    state_d    = S_FAIL;
                    err_code_d = fault_code;
                    err_idx_d  = index_q;
`endif
                end
            end
            S_GAP: begin
                timer_d = timer_q + TW'(1);
                if (timer_q == TW'(GAP_CYCLES - 1)) begin
                    state_d = S_LOAD;
                    timer_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Operands follow the next index so they are already settled when LOAD begins.
        entry  = init_entry(index_d);
        reg_d  = entry[15:9];
        data_d = entry[8:0];
    end

    always_ff @(posedge i_i2c_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q    <= S_IDLE;
            index_q    <= 4'd0;
            timer_q    <= '0;
            err_code_q <= 4'h0;
            err_idx_q  <= 4'h0;
            reg_q      <= 7'h0F;
            data_q     <= 9'h000;
`ifdef CODEC_CFG_RETRY_EN
            retry_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            timer_q    <= timer_d;
            err_code_q <= err_code_d;
            err_idx_q  <= err_idx_d;
            reg_q      <= reg_d;
            data_q     <= data_d;
`ifdef CODEC_CFG_RETRY_EN
            retry_q    <= retry_d;
`endif
        end
    end

    // Decoded straight from state so an async reset drops the master reset at once.
    assign o_m_nrst           = (state_q == S_RUN);
    assign o_busy             = (state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_GAP);
    assign o_done             = (state_q == S_DONE);
    assign o_error            = (state_q == S_FAIL);
    assign o_error_code       = err_code_q;
    assign o_error_index      = err_idx_q;
    assign o_m_addr           = I2C_ADDR;
    assign o_m_register       = reg_q;
    assign o_m_data           = data_q;
    assign o_m_read_not_write = 1'b0;

endmodule
